// File: rtl/data_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_port
// Purpose  : MEM-stage load/store responder driving a word-addressed req/ack
//            data bus; stalls the pipeline until the access completes.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_port #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        is_memory_instruction_i,
  input  logic [3:0]  read_write_sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busywait_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_f3;
  logic [1:0]         r_off;

  logic [2:0]  w_f3;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_f3 = read_write_sel_i[2:0];

  always_comb begin
    w_mis   = 1'b0;
    w_be    = 4'b1111;
    w_wdata = wdata_i;
    case (w_f3)
      3'b000, 3'b100: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      3'b001, 3'b101: begin
        w_mis   = addr_i[0];
        w_be    = 4'b0011 << {addr_i[1], 1'b0};
        w_wdata = {2{wdata_i[15:0]}};
      end
      3'b010:  w_mis = (addr_i[1:0] != 2'b00);
      default: w_mis = 1'b1;
    endcase
  end

  // Lane selection uses the offset captured with the request, since addr_i
  // may no longer be meaningful once the response arrives.
  always_comb begin
    case (r_off)
      2'd0:    w_byte = mem_rdata_i[7:0];
      2'd1:    w_byte = mem_rdata_i[15:8];
      2'd2:    w_byte = mem_rdata_i[23:16];
      default: w_byte = mem_rdata_i[31:24];
    endcase
    w_half = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = mem_rdata_i;
    endcase
  end

  assign busywait_o   = (r_state == S_WAIT) ||
                        ((r_state == S_IDLE) && is_memory_instruction_i && !w_mis);
  assign misaligned_o = (r_state == S_IDLE) && is_memory_instruction_i && w_mis;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_f3        <= 3'd0;
      r_off       <= 2'd0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_be_o    <= 4'd0;
      mem_wdata_o <= 32'd0;
      load_data_o <= 32'd0;
      bus_err_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (is_memory_instruction_i && !w_mis) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= read_write_sel_i[3];
            mem_addr_o  <= {addr_i[31:2], 2'b00};
            mem_be_o    <= w_be;
            mem_wdata_o <= w_wdata;
            r_f3        <= w_f3;
            r_off       <= addr_i[1:0];
            r_cnt       <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            mem_req_o   <= 1'b0;
            load_data_o <= mem_we_o ? 32'd0 : w_ext;
            bus_err_o   <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_cnt == c_cnt_last) begin
            mem_req_o   <= 1'b0;
            load_data_o <= 32'd0;
            bus_err_o   <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
